pc_target_unit: RTL and testbench

Registered control-flow target generator for the ID stage. It computes jump, jump-register and conditional-branch targets from the ID-stage PC+4 and instruction fields, and produces a taken flag and a link address for JAL/JALR. It also keeps a small return-address stack (RAS) whose top is compared against the JR source register. Results feed the IF-stage PC mux and the hazard/flush logic one cycle after the instruction is accepted.

---
 rtl/pc_target_unit.sv | 188 ++++++++++++++++++
 tb/tb_pc_target_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_target_unit.sv
// ID-stage control-flow target generator: registered jump/branch targets, link address and a
// small circular return-address stack checked against the JR source register.
module pc_target_unit #(
   parameter int unsigned BITS_SIZE = 32,
   parameter int unsigned BITS_JUMP = 26,
   parameter int unsigned BITS_IMM  = 16,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic [2:0]           i_type,
   input  logic [BITS_SIZE-1:0] i_pc4,
   input  logic [BITS_JUMP-1:0] i_jump,
   input  logic [BITS_IMM-1:0]  i_imm,
   input  logic [BITS_SIZE-1:0] i_rs_data,
   input  logic [BITS_SIZE-1:0] i_rt_data,
   output logic [BITS_SIZE-1:0] o_target,
   output logic                 o_taken,
   output logic [BITS_SIZE-1:0] o_link,
   output logic                 o_link_we,
   output logic                 o_ras_valid,
   output logic                 o_ras_hit,
   output logic                 o_ras_empty,
   output logic                 o_ras_full
);

   localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(RAS_DEPTH);

   typedef enum logic [2:0] {
      OpNone = 3'd0,
      OpJ    = 3'd1,
      OpJal  = 3'd2,
      OpJr   = 3'd3,
      OpJalr = 3'd4,
      OpBeq  = 3'd5,
      OpBne  = 3'd6,
      OpRsvd = 3'd7
   } op_e;

   op_e op;
   assign op = op_e'(i_type);

   // Registered outputs and RAS bookkeeping
   logic [BITS_SIZE-1:0] target_q, target_d;
   logic [BITS_SIZE-1:0] link_q, link_d;
   logic                 taken_q, taken_d;
   logic                 link_we_q, link_we_d;
   logic                 ras_valid_q, ras_valid_d;
   logic                 ras_hit_q, ras_hit_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 ras_push;

   logic [BITS_SIZE-1:0] ras_mem [RAS_DEPTH];

   // Target candidates
   logic [BITS_SIZE-1:0] j_target;
   logic [BITS_SIZE-1:0] br_offset;
   logic [BITS_SIZE-1:0] br_target;
   logic [BITS_SIZE-1:0] ras_top;
   logic [PtrW-1:0]      top_ptr;
   logic                 rs_eq_rt;
   logic                 ras_nonempty;

   assign j_target  = {i_pc4[BITS_SIZE-1:BITS_JUMP+2], i_jump, 2'b00};
   assign br_offset = {{(BITS_SIZE-BITS_IMM-2){i_imm[BITS_IMM-1]}}, i_imm, 2'b00};
   assign br_target = i_pc4 + br_offset;
   assign rs_eq_rt  = (i_rs_data == i_rt_data);

   // The write pointer names the next free slot, so the top of stack sits one below it.
   assign top_ptr      = wr_ptr_q - PtrW'(1);
   assign ras_top      = ras_mem[top_ptr];
   assign ras_nonempty = (cnt_q != '0);

   always_comb begin
      target_d    = target_q;
      link_d      = link_q;
      taken_d     = taken_q;
      link_we_d   = link_we_q;
      ras_valid_d = ras_valid_q;
      ras_hit_d   = ras_hit_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      ras_push    = 1'b0;

      if (i_flush || (!i_stall && !i_valid)) begin
         taken_d     = 1'b0;
         link_we_d   = 1'b0;
         ras_valid_d = 1'b0;
         ras_hit_d   = 1'b0;
      end else if (!i_stall) begin
         target_d    = '0;
         link_d      = i_pc4;
         taken_d     = 1'b0;
         link_we_d   = 1'b0;
         ras_valid_d = 1'b0;
         ras_hit_d   = 1'b0;

         case (op)
            OpJ: begin
               target_d = j_target;
               taken_d  = 1'b1;
            end
            OpJal: begin
               target_d  = j_target;
               taken_d   = 1'b1;
               link_we_d = 1'b1;
               ras_push  = 1'b1;
            end
            OpJr: begin
               target_d = i_rs_data;
               taken_d  = 1'b1;
               if (ras_nonempty) begin
                  ras_valid_d = 1'b1;
                  ras_hit_d   = (ras_top == i_rs_data);
                  wr_ptr_d    = top_ptr;
                  cnt_d       = cnt_q - CntW'(1);
               end
            end
            OpJalr: begin
               target_d  = i_rs_data;
               taken_d   = 1'b1;
               link_we_d = 1'b1;
               ras_push  = 1'b1;
            end
            OpBeq: begin
               target_d = br_target;
               taken_d  = rs_eq_rt;
            end
            OpBne: begin
               target_d = br_target;
               taken_d  = !rs_eq_rt;
            end
            default: ;
         endcase

         // A push when full wraps onto the oldest slot; the count simply saturates.
         if (ras_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            cnt_d    = (cnt_q == DepthCnt) ? cnt_q : cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         target_q    <= '0;
         link_q      <= '0;
         taken_q     <= 1'b0;
         link_we_q   <= 1'b0;
         ras_valid_q <= 1'b0;
         ras_hit_q   <= 1'b0;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         target_q    <= target_d;
         link_q      <= link_d;
         taken_q     <= taken_d;
         link_we_q   <= link_we_d;
         ras_valid_q <= ras_valid_d;
         ras_hit_q   <= ras_hit_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   // Entries need no reset: a pop requires a nonzero count, which only pushes after reset raise.
   always_ff @(posedge i_clk) begin
      if (!i_reset && ras_push) begin
         ras_mem[wr_ptr_q] <= i_pc4;
      end
   end

   assign o_target    = target_q;
   assign o_taken     = taken_q;
   assign o_link      = link_q;
   assign o_link_we   = link_we_q;
   assign o_ras_valid = ras_valid_q;
   assign o_ras_hit   = ras_hit_q;
   assign o_ras_empty = (cnt_q == '0);
   assign o_ras_full  = (cnt_q == DepthCnt);

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed bench for pc_target_unit: queue-based reference model checked every cycle, plus
// hand-computed literal expectations for the key scenarios.
module tb_pc_target_unit;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, valid, stall, flush;
   logic [2:0]  ty;
   logic [31:0] pc4, rs, rt;
   logic [25:0] jmp;
   logic [15:0] imm;

   logic [31:0] target, link;
   logic        taken, link_we, ras_valid, ras_hit, ras_empty, ras_full;

   pc_target_unit #(
      .BITS_SIZE(32),
      .BITS_JUMP(26),
      .BITS_IMM (16),
      .RAS_DEPTH(DEPTH)
   ) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_valid    (valid),
      .i_stall    (stall),
      .i_flush    (flush),
      .i_type     (ty),
      .i_pc4      (pc4),
      .i_jump     (jmp),
      .i_imm      (imm),
      .i_rs_data  (rs),
      .i_rt_data  (rt),
      .o_target   (target),
      .o_taken    (taken),
      .o_link     (link),
      .o_link_we  (link_we),
      .o_ras_valid(ras_valid),
      .o_ras_hit  (ras_hit),
      .o_ras_empty(ras_empty),
      .o_ras_full (ras_full)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit check_en = 1'b0;

   // Reference model state
   logic [31:0] m_target, m_link;
   logic        m_taken, m_link_we, m_rv, m_rh;
   logic [31:0] m_ras[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model update using the inputs presented at the edge just taken
   task automatic model_update();
      logic [31:0] e;
      if (reset) begin
         m_target = 0; m_link = 0; m_taken = 0; m_link_we = 0; m_rv = 0; m_rh = 0;
         m_ras.delete();
      end else if (flush || (!stall && !valid)) begin
         m_taken = 0; m_link_we = 0; m_rv = 0; m_rh = 0;
      end else if (!stall) begin
         m_link = pc4; m_taken = 0; m_link_we = 0; m_rv = 0; m_rh = 0; m_target = 0;
         case (ty)
            3'd1, 3'd2: begin
               m_target = (pc4 & 32'hF000_0000) | (32'(jmp) * 4);
               m_taken  = 1;
            end
            3'd3, 3'd4: begin
               m_target = rs;
               m_taken  = 1;
            end
            3'd5, 3'd6: begin
               m_target = pc4 + 32'(int'($signed(imm)) * 4);
               m_taken  = (ty == 3'd5) ? (rs == rt) : (rs != rt);
            end
            default: ;
         endcase
         if (ty == 3'd2 || ty == 3'd4) m_link_we = 1;
         if (ty == 3'd3 && m_ras.size() > 0) begin
            e    = m_ras.pop_back();
            m_rv = 1;
            m_rh = (e == rs);
         end
         if (ty == 3'd2 || ty == 3'd4) begin
            m_ras.push_back(pc4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("target", target, m_target);
         chk("taken", 32'(taken), 32'(m_taken));
         chk("link", link, m_link);
         chk("link_we", 32'(link_we), 32'(m_link_we));
         chk("ras_valid", 32'(ras_valid), 32'(m_rv));
         chk("ras_hit", 32'(ras_hit), 32'(m_rh));
         chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
         chk("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
      end
   end

   task automatic step(input logic r, input logic v, input logic s, input logic f,
                       input logic [2:0] t, input logic [31:0] p, input logic [25:0] j,
                       input logic [15:0] im, input logic [31:0] a, input logic [31:0] b);
      reset = r; valid = v; stall = s; flush = f; ty = t; pc4 = p; jmp = j; imm = im;
      rs = a; rt = b;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic ins(input logic [2:0] t, input logic [31:0] p, input logic [25:0] j,
                      input logic [15:0] im, input logic [31:0] a, input logic [31:0] b);
      step(1'b0, 1'b1, 1'b0, 1'b0, t, p, j, im, a, b);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_en = 1'b1;
      chk("lit_reset_empty", 32'(ras_empty), 32'd1);
      chk("lit_reset_target", target, 32'h0);
      chk("lit_reset_taken", 32'(taken), 32'd0);

      // J
      ins(3'd1, 32'h1000_0004, 26'h000_0040, 16'h0, 0, 0);
      chk("lit_j_target", target, 32'h1000_0100);
      chk("lit_j_model", m_target, 32'h1000_0100);
      chk("lit_j_taken", 32'(taken), 32'd1);
      chk("lit_j_link_we", 32'(link_we), 32'd0);

      // BEQ / BNE with negative offset
      ins(3'd5, 32'h0000_0010, 26'h0, 16'hFFFC, 32'd5, 32'd5);
      chk("lit_beq_target", target, 32'h0);
      chk("lit_beq_taken", 32'(taken), 32'd1);
      ins(3'd6, 32'h0000_0010, 26'h0, 16'hFFFC, 32'd5, 32'd5);
      chk("lit_bne_target", target, 32'h0);
      chk("lit_bne_taken", 32'(taken), 32'd0);
      ins(3'd6, 32'hFFFF_FFF0, 26'h0, 16'h0008, 32'd1, 32'd2);
      chk("lit_bne_wrap", target, 32'h0000_0010);
      ins(3'd7, 32'h1234_5678, 26'h3FF_FFFF, 16'h7FFF, 32'd1, 32'd1);
      chk("lit_rsvd_target", target, 32'h0);

      // JAL then matching JR
      ins(3'd2, 32'h0040_0008, 26'h0, 16'h0, 0, 0);
      chk("lit_jal_link", link, 32'h0040_0008);
      chk("lit_jal_link_we", 32'(link_we), 32'd1);
      chk("lit_jal_empty", 32'(ras_empty), 32'd0);
      ins(3'd3, 32'h0, 26'h0, 16'h0, 32'h0040_0008, 0);
      chk("lit_jr_valid", 32'(ras_valid), 32'd1);
      chk("lit_jr_hit", 32'(ras_hit), 32'd1);
      chk("lit_jr_empty", 32'(ras_empty), 32'd1);

      // Overfill: A0..A4, pops must return A4..A1 then run dry
      for (int i = 0; i <= DEPTH; i++) ins(3'd2, 32'h0000_1000 * (i + 1), 26'h0, 16'h0, 0, 0);
      chk("lit_full", 32'(ras_full), 32'd1);
      for (int i = DEPTH; i >= 1; i--) begin
         ins(3'd3, 32'h0, 26'h0, 16'h0, 32'h0000_1000 * (i + 1), 0);
         chk("lit_pop_hit", 32'(ras_hit), 32'd1);
      end
      ins(3'd3, 32'h0, 26'h0, 16'h0, 32'h0000_2000, 0);
      chk("lit_pop_dry", 32'(ras_valid), 32'd0);

      // JALR pushes, JR with wrong rs misses
      ins(3'd4, 32'h0000_0600, 26'h0, 16'h0, 32'h0000_1234, 0);
      chk("lit_jalr_target", target, 32'h0000_1234);
      ins(3'd3, 32'h0, 26'h0, 16'h0, 32'h0000_0604, 0);
      chk("lit_jr_miss_valid", 32'(ras_valid), 32'd1);
      chk("lit_jr_miss_hit", 32'(ras_hit), 32'd0);

      // JAL, stall 3 cycles with changing type, then flush
      ins(3'd2, 32'h2000_0000, 26'h000_0010, 16'h0, 0, 0);
      step(0, 1, 1, 0, 3'd3, 32'h1, 26'h1, 16'h1, 32'h2000_0000, 0);
      step(0, 1, 1, 0, 3'd5, 32'h2, 26'h2, 16'h2, 32'h7, 32'h7);
      step(0, 1, 1, 0, 3'd1, 32'h3, 26'h3, 16'h3, 32'h0, 32'h0);
      chk("lit_stall_target", target, 32'h2000_0040);
      chk("lit_stall_link_we", 32'(link_we), 32'd1);
      chk("lit_stall_empty", 32'(ras_empty), 32'd0);
      step(0, 1, 1, 1, 3'd1, 32'h4, 26'h4, 16'h4, 0, 0);
      chk("lit_flush_taken", 32'(taken), 32'd0);
      chk("lit_flush_link_we", 32'(link_we), 32'd0);
      chk("lit_flush_target", target, 32'h2000_0040);
      ins(3'd1, 32'h3000_0004, 26'h000_0001, 16'h0, 0, 0);
      step(0, 0, 0, 0, 3'd2, 32'h5, 26'h5, 16'h5, 0, 0);
      chk("lit_novalid_target", target, 32'h3000_0004);
      chk("lit_novalid_taken", 32'(taken), 32'd0);

      // Two pushes, reset during stall
      ins(3'd2, 32'h0000_0A00, 26'h0, 16'h0, 0, 0);
      ins(3'd4, 32'h0000_0B00, 26'h0, 16'h0, 32'h44, 0);
      step(1, 1, 1, 0, 3'd2, 32'h0000_0C00, 26'h0, 16'h0, 0, 0);
      chk("lit_rst_empty", 32'(ras_empty), 32'd1);
      chk("lit_rst_target", target, 32'h0);
      chk("lit_rst_link", link, 32'h0);
      ins(3'd3, 32'h0, 26'h0, 16'h0, 32'h0000_0B00, 0);
      chk("lit_rst_jr_valid", 32'(ras_valid), 32'd0);
      ins(3'd0, 32'h9, 26'h0, 16'h0, 0, 0);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
